// File: rtl/sl_sram_fill_pkg.sv
// rtl/sl_sram_fill_pkg.sv - state encoding, AHB constants and fill-pattern helper for sl_ahb_sram_fill
package sl_sram_fill_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Pattern configuration captured on an accepted START
    typedef struct packed {
        logic [31:0] pattern;
        logic        mode;
    } fill_cfg_t;

    // Word value for index i: constant pattern, or pattern plus index (mod 2^32)
    function automatic logic [31:0] fill_data(input logic [31:0] pattern,
                                              input logic        mode,
                                              input logic [31:0] index);
        return mode ? (pattern + index) : pattern;
    endfunction

endpackage

// File: rtl/sl_sram_fill_pattern.sv
// rtl/sl_sram_fill_pattern.sv - word-index counter with address and data generation, shared by fill and verify passes
module sl_sram_fill_pattern
    import sl_sram_fill_pkg::*;
#(
    parameter int RAM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  restart,
    input  logic                  advance,
    input  logic [RAM_ADDR_W-1:0] base,
    input  logic [RAM_ADDR_W-2:0] words,
    input  logic [31:0]           pattern,
    input  logic                  mode,
    output logic [RAM_ADDR_W-1:0] addr,
    output logic [31:0]           data,
    output logic                  last
);

    localparam int IW = RAM_ADDR_W - 1;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

    logic [RAM_ADDR_W-3:0] base_word;
    logic [IW-1:0]         words_q;
    logic [IW-1:0]         idx;
    fill_cfg_t             cfg;
    logic                  unused_base;

    // Byte offset bits of BASE carry no meaning: transfers are always word aligned
    assign unused_base = ^base[1:0];

    // Capture the request on load; step or rewind the word index afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_word <= '0;
            words_q   <= '0;
            cfg       <= '0;
            idx       <= '0;
        end else if (load) begin
            base_word   <= base[RAM_ADDR_W-1:2];
            words_q     <= words;
            cfg.pattern <= pattern;
            cfg.mode    <= mode;
            idx         <= '0;
        end else if (restart) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + IDX_ONE;
        end
    end

    // Word-granular add wraps the address silently at the top of the region
    assign addr = {base_word + idx[RAM_ADDR_W-3:0], 2'b00};
    assign data = fill_data(cfg.pattern, cfg.mode, 32'(idx));
    assign last = (idx == (words_q - IDX_ONE));

endmodule

// File: rtl/sl_ahb_sram_fill.sv
// rtl/sl_ahb_sram_fill.sv - AHB-Lite SRAM fill master; optional read-back verify under SL_SRAM_FILL_VERIFY_EN
module sl_ahb_sram_fill
    import sl_sram_fill_pkg::*;
#(
    parameter int SYS_DATA_W = 32,
    parameter int RAM_ADDR_W = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  START,
    input  logic [RAM_ADDR_W-1:0] BASE,
    input  logic [RAM_ADDR_W-2:0] WORDS,
    input  logic [31:0]           PATTERN,
    input  logic                  MODE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [RAM_ADDR_W-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic                  HWRITE,
    output logic [SYS_DATA_W-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [SYS_DATA_W-1:0] HRDATA
);

    logic [1:0]            state;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [1:0]            htrans_q;
    logic                  hwrite_q;
    logic [SYS_DATA_W-1:0] hwdata_q;
    logic                  dphase_valid;

    logic                  start_ok;
    logic                  accept;
    logic                  err_first;
    logic                  gen_restart;
    logic                  gen_advance;
    logic                  gen_last;
    logic [31:0]           gen_data;
    logic [RAM_ADDR_W-1:0] gen_addr;

    // START is honoured only from a quiet IDLE (not in the DONE cycle, when BUSY is still high)
    assign start_ok  = (state == ST_IDLE) && !busy_q && START;
    assign accept    = (htrans_q == HTRANS_NONSEQ) && HREADY;
    // First cycle of the two-cycle AHB error response for the beat in data phase
    assign err_first = dphase_valid && HRESP && !HREADY;
    assign gen_advance = accept && !gen_last;

`ifdef SL_SRAM_FILL_VERIFY_EN
    logic                  dphase_read;
    logic [SYS_DATA_W-1:0] dphase_exp;
    logic                  mismatch;

    assign gen_restart = accept && gen_last && (state == ST_FILL);
    assign mismatch    = dphase_valid && dphase_read && HREADY && !HRESP
                         && (HRDATA != dphase_exp);
`else
    logic unused_hrdata;

    assign gen_restart   = 1'b0;
    assign unused_hrdata = ^HRDATA;
`endif

    sl_sram_fill_pattern #(
        .RAM_ADDR_W (RAM_ADDR_W)
    ) u_pattern (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .load    (start_ok),
        .restart (gen_restart),
        .advance (gen_advance),
        .base    (BASE),
        .words   (WORDS),
        .pattern (PATTERN),
        .mode    (MODE),
        .addr    (gen_addr),
        .data    (gen_data),
        .last    (gen_last)
    );

    // Transfer sequencing: address phase, registered data phase and completion status
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            dphase_valid <= 1'b0;
`ifdef SL_SRAM_FILL_VERIFY_EN
            dphase_read  <= 1'b0;
            dphase_exp   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (HREADY) begin
                dphase_valid <= accept;
            end
            if (accept && hwrite_q) begin
                hwdata_q <= gen_data;
            end
`ifdef SL_SRAM_FILL_VERIFY_EN
            if (accept) begin
                dphase_read <= !hwrite_q;
                dphase_exp  <= gen_data;
            end
            if (mismatch) begin
                error_q <= 1'b1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (START) begin
                        error_q <= 1'b0;
                        if (WORDS != '0) begin
                            state    <= ST_FILL;
                            busy_q   <= 1'b1;
                            htrans_q <= HTRANS_NONSEQ;
                            hwrite_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (err_first) begin
                        error_q  <= 1'b1;
                        htrans_q <= HTRANS_IDLE;
                        state    <= ST_DRAIN;
                    end else if (accept && gen_last) begin
                        htrans_q <= HTRANS_IDLE;
`ifdef SL_SRAM_FILL_VERIFY_EN
                        state    <= ST_CHECK;
`else
                        state    <= ST_DRAIN;
`endif
                    end
                end
`ifdef SL_SRAM_FILL_VERIFY_EN
                ST_CHECK: begin
                    if (err_first) begin
                        error_q  <= 1'b1;
                        htrans_q <= HTRANS_IDLE;
                        state    <= ST_DRAIN;
                    end else if (htrans_q == HTRANS_IDLE) begin
                        // One idle slot lets the last write data phase retire before reads start
                        if (HREADY) begin
                            htrans_q <= HTRANS_NONSEQ;
                            hwrite_q <= 1'b0;
                        end
                    end else if (accept && gen_last) begin
                        htrans_q <= HTRANS_IDLE;
                        state    <= ST_DRAIN;
                    end
                end
`endif
                ST_DRAIN: begin
                    if (err_first) begin
                        error_q <= 1'b1;
                    end else if (HREADY) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERROR  = error_q;
    assign HADDR  = gen_addr;
    assign HTRANS = htrans_q;
    assign HSIZE  = HSIZE_WORD;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;

endmodule

// File: tb/tb_sl_ahb_sram_fill.sv
// tb/tb_sl_ahb_sram_fill.sv - self-checking bench for sl_ahb_sram_fill with an AHB SRAM slave model
`timescale 1ns/1ps
module tb_sl_ahb_sram_fill;

    localparam int AW = 14;
`ifdef SL_SRAM_FILL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam logic [31:0] SENT = 32'hA5A5_5A5A;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] BASE = '0;
    logic [AW-2:0] WORDS = '0;
    logic [31:0]   PATTERN = '0;
    logic          MODE = 1'b0;
    logic          BUSY, DONE, ERROR;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;
    logic [31:0]   HRDATA = '0;

    sl_ahb_sram_fill dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .START(START), .BASE(BASE), .WORDS(WORDS),
        .PATTERN(PATTERN), .MODE(MODE), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] base;
        int            words;
        logic [31:0]   pattern;
        logic          mode;
        bit            stall;
        int            err_beat;
        bit            corrupt;
        bit            poke;
        bit            check_lat;
        bit            exp_error;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          write;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         sb_e;
    logic [31:0] mem [0:4095];
    vec_t        vecs [0:6];

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    bit dp_valid = 0;
    logic [AW-1:0] dp_addr = '0;
    logic dp_write = 1'b0;
    int dp_beat = 0;
    int err_state = 0;
    int accept_cnt = 0;
    bit stall_en = 0;
    int err_beat_cfg = -1;
    bit corrupt_en = 0;
    bit corrupt_done = 0;
    int corrupt_word = 0;
    bit arm = 0;
    int start_cyc = -1;
    int first_nonseq = -1;
    int done_cyc = -1;
    bit busy_seen = 0;
    bit busy_at_first = 0;
    bit busy_at_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input int i);
        logic [AW-1:0] b;
        b = base & ~14'h3;
        return AW'(32'(b) + 32'(4 * i));
    endfunction

    function automatic int word_of(input logic [AW-1:0] base, input int i);
        return int'(addr_of(base, i) >> 2);
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] pattern, input logic mode, input int i);
        return mode ? pattern + 32'(i) : pattern;
    endfunction

    // AHB SRAM slave model and monitor: decides HREADY/HRESP for the cycle and retires beats
    always @(negedge HCLK) begin
        cyc++;
        if (!HRESETn) begin
            dp_valid  = 0;
            err_state = 0;
            HREADY    = 1'b1;
            HRESP     = 1'b0;
        end else begin
            if (arm && START) begin
                start_cyc    = cyc;
                arm          = 0;
                first_nonseq = -1;
                done_cyc     = -1;
                accept_cnt   = 0;
                busy_seen    = 0;
            end
            if (HTRANS == 2'b10 && first_nonseq < 0) begin
                first_nonseq  = cyc;
                busy_at_first = BUSY;
            end
            if (BUSY) busy_seen = 1;
            if (DONE && done_cyc < 0) begin
                done_cyc     = cyc;
                busy_at_done = BUSY;
            end

            if (err_state == 1) begin
                HREADY    = 1'b1;
                HRESP     = 1'b1;
                err_state = 0;
                chk("err_cycle2_htrans_idle", 32'(HTRANS), 32'd0);
            end else if (dp_valid && dp_beat == err_beat_cfg) begin
                HREADY    = 1'b0;
                HRESP     = 1'b1;
                err_state = 1;
            end else begin
                HRESP  = 1'b0;
                HREADY = (stall_en && dp_valid) ? ($urandom_range(0, 2) != 0) : 1'b1;
            end

            if (dp_valid && !dp_write && HREADY) HRDATA = mem[int'(dp_addr >> 2)];

            if (HREADY) begin
                if (dp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra_beat: got beat at 0x%04h, expected no beat", dp_addr);
                    end else begin
                        sb_e = sb_q.pop_front();
                        chk("beat_addr", 32'(dp_addr), 32'(sb_e.addr));
                        chk("beat_write", 32'(dp_write), 32'(sb_e.write));
                        if (dp_write) begin
                            chk("beat_wdata", HWDATA, sb_e.data);
                            if (!HRESP) mem[int'(dp_addr >> 2)] = HWDATA;
                        end
                    end
                end
                if (HTRANS == 2'b10) begin
                    dp_valid = 1;
                    dp_addr  = HADDR;
                    dp_write = HWRITE;
                    dp_beat  = accept_cnt;
                    accept_cnt++;
                    if (!HWRITE && corrupt_en && !corrupt_done) begin
                        mem[corrupt_word] = mem[corrupt_word] ^ 32'h1;
                        corrupt_done = 1;
                    end
                end else begin
                    dp_valid = 0;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int vi);
        int n;
        int exp_beats;
        int exp_acc;
        logic [31:0] expw;
        sb_t e;
        n = v.words;
        for (int i = 0; i <= n; i++) mem[word_of(v.base, i)] = SENT;
        stall_en     = v.stall;
        err_beat_cfg = v.err_beat;
        corrupt_en   = v.corrupt;
        corrupt_done = 0;
        corrupt_word = word_of(v.base, 1);
        exp_beats = (v.err_beat >= 0) ? v.err_beat + 1 : n;
        exp_acc   = exp_beats;
        for (int i = 0; i < exp_beats; i++) begin
            e.addr = addr_of(v.base, i); e.data = data_of(v.pattern, v.mode, i); e.write = 1'b1;
            sb_q.push_back(e);
        end
        if (VERIFY && v.err_beat < 0) begin
            exp_acc = 2 * n;
            for (int i = 0; i < n; i++) begin
                e.addr = addr_of(v.base, i); e.data = data_of(v.pattern, v.mode, i); e.write = 1'b0;
                sb_q.push_back(e);
            end
        end

        @(posedge HCLK); #1;
        BASE = v.base; WORDS = 13'(n); PATTERN = v.pattern; MODE = v.mode; START = 1'b1; arm = 1;
        @(posedge HCLK); #1;
        START = 1'b0;
        if (v.poke) begin
            repeat (3) @(posedge HCLK);
            #1;
            BASE = 14'h0800; WORDS = 13'd2; MODE = 1'b0; START = 1'b1;
            @(posedge HCLK); #1;
            START = 1'b0;
        end
        for (int t = 0; t < 400; t++) begin
            if (done_cyc >= 0) break;
            @(posedge HCLK);
        end
        chk($sformatf("v%0d_done_seen", vi), 32'(done_cyc >= 0), 32'd1);
        repeat (2) @(posedge HCLK);
        #1;
        chk($sformatf("v%0d_error", vi), 32'(ERROR), 32'(v.exp_error));
        chk($sformatf("v%0d_busy_after", vi), 32'(BUSY), 32'd0);
        if (n == 0) begin
            chk($sformatf("v%0d_no_nonseq", vi), 32'(first_nonseq), 32'hFFFF_FFFF);
            chk($sformatf("v%0d_busy_never", vi), 32'(busy_seen), 32'd0);
            chk($sformatf("v%0d_done_latency", vi), 32'(done_cyc - start_cyc), 32'd1);
        end else begin
            chk($sformatf("v%0d_first_nonseq", vi), 32'(first_nonseq - start_cyc), 32'd1);
            chk($sformatf("v%0d_busy_first", vi), 32'(busy_at_first), 32'd1);
            chk($sformatf("v%0d_busy_done", vi), 32'(busy_at_done), 32'd1);
            if (v.check_lat)
                chk($sformatf("v%0d_latency", vi), 32'(done_cyc - first_nonseq),
                    32'(VERIFY ? 2 * n + 2 : n + 1));
        end
        chk($sformatf("v%0d_accepts", vi), 32'(accept_cnt), 32'(exp_acc));
        chk($sformatf("v%0d_sb_empty", vi), 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        for (int i = 0; i <= n; i++) begin
            expw = (i < n && (v.err_beat < 0 || i < v.err_beat)) ? data_of(v.pattern, v.mode, i) : SENT;
            if (v.corrupt && i == 1) expw = expw ^ 32'h1;
            chk($sformatf("v%0d_mem%0d", vi, i), mem[word_of(v.base, i)], expw);
        end
        stall_en = 0; err_beat_cfg = -1; corrupt_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        vecs[0] = '{base:14'h0100, words:4, pattern:32'hDEADBEEF, mode:1'b0, stall:0, err_beat:-1, corrupt:0, poke:0, check_lat:1, exp_error:0};
        vecs[1] = '{base:14'h3FF8, words:3, pattern:32'h0000_0010, mode:1'b1, stall:0, err_beat:-1, corrupt:0, poke:0, check_lat:1, exp_error:0};
        vecs[2] = '{base:14'h0200, words:0, pattern:32'h0000_0055, mode:1'b0, stall:0, err_beat:-1, corrupt:0, poke:0, check_lat:0, exp_error:0};
        vecs[3] = '{base:14'h0603, words:8, pattern:32'hFFFF_FFFE, mode:1'b1, stall:1, err_beat:-1, corrupt:0, poke:1, check_lat:0, exp_error:0};
        vecs[4] = '{base:14'h0400, words:6, pattern:32'h1234_5678, mode:1'b0, stall:0, err_beat:2,  corrupt:0, poke:0, check_lat:0, exp_error:1};
        vecs[5] = '{base:14'h0700, words:1, pattern:32'hCAFE_F00D, mode:1'b0, stall:0, err_beat:-1, corrupt:0, poke:0, check_lat:1, exp_error:0};
        vecs[6] = '{base:14'h0A00, words:4, pattern:32'h0BAD_0000, mode:1'b1, stall:0, err_beat:-1, corrupt:1, poke:0, check_lat:1, exp_error:1};
        nv = VERIFY ? 7 : 6;

        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_error", 32'(ERROR), 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", 32'(HADDR), 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd2);
        HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);

        for (int vi = 0; vi < nv; vi++) begin
            if (vi == 5) chk("error_sticky_before_start", 32'(ERROR), 32'd1);
            run_vec(vecs[vi], vi);
        end

        // Reset in the middle of a stalled fill: outputs drop at once and no DONE follows
        stall_en = 1;
        for (int i = 0; i < 8; i++) begin
            sb_e.addr = addr_of(14'h0900, i); sb_e.data = 32'h7777_0000; sb_e.write = 1'b1;
            sb_q.push_back(sb_e);
        end
        @(posedge HCLK); #1;
        BASE = 14'h0900; WORDS = 13'd8; PATTERN = 32'h7777_0000; MODE = 1'b0; START = 1'b1; arm = 1;
        @(posedge HCLK); #1;
        START = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_htrans", 32'(HTRANS), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        stall_en = 0;
        sb_q.delete();
        done_cyc = -1;
        repeat (20) @(posedge HCLK);
        #1;
        chk("rst_mid_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        chk("rst_mid_idle", 32'(HTRANS), 32'd0);

        run_vec(vecs[0], 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
